// File: rtl/rvm_sim_monitor.sv
// Run-control monitor: matches accepted bus transfers against pass/fail/halt watch channels,
// enforces a cycle timeout and latches a sticky verdict. Optional stall counter: RVM_MONITOR_STALL_COUNT_EN.
module rvm_sim_monitor #(
   parameter int                NUM_WATCH = 4,
   parameter int                ADDR_W    = 32,
   parameter int                CYC_W     = 32,
   parameter int                IDX_W     = 4,
   parameter logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(32'h0FFF_FFFF)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [ADDR_W-1:0]           mem_addr,
   input  logic                        mem_c_en,
   input  logic                        mem_stall,
   input  logic [NUM_WATCH*ADDR_W-1:0] cfg_addr,
   input  logic [2*NUM_WATCH-1:0]      cfg_kind,
   input  logic [CYC_W-1:0]            cfg_max_cycles,
   input  logic                        start,
   output logic                        running,
   output logic                        done,
   output logic                        pass,
   output logic                        fail_hit,
   output logic                        halt_hit,
   output logic                        timeout,
   output logic [IDX_W-1:0]            hit_index,
   output logic [CYC_W-1:0]            cycle_count,
   output logic [CYC_W-1:0]            stall_count
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   localparam logic [1:0] K_PASS = 2'b01;
   localparam logic [1:0] K_FAIL = 2'b10;
   localparam logic [1:0] K_HALT = 2'b11;

   state_t           state_q, state_d;
   logic [CYC_W-1:0] cycle_q, cycle_d, cyc_inc;
   logic             pass_q, pass_d, fail_q, fail_d, halt_q, halt_d, tmo_q, tmo_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   logic             accepted, match, tmo_now;
   logic [IDX_W-1:0] match_idx;
   logic [1:0]       match_kind;
   logic [ADDR_W-1:0] addr_m;

   assign accepted = mem_c_en && !mem_stall;
   assign addr_m   = mem_addr & ADDR_MASK;
   assign cyc_inc  = (&cycle_q) ? cycle_q : cycle_q + CYC_W'(1);

   // Scan high to low so the lowest matching channel is the last one written.
   always_comb begin
      match      = 1'b0;
      match_idx  = '0;
      match_kind = 2'b00;
      for (int k = NUM_WATCH - 1; k >= 0; k--) begin
         if (accepted && (cfg_kind[2*k +: 2] != 2'b00) &&
             (addr_m == (cfg_addr[k*ADDR_W +: ADDR_W] & ADDR_MASK))) begin
            match      = 1'b1;
            match_idx  = IDX_W'(k);
            match_kind = cfg_kind[2*k +: 2];
         end
      end
   end

   assign tmo_now = (cfg_max_cycles != '0) && (cyc_inc == cfg_max_cycles) && !match;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (start) state_d = RUN;
                  else if (match || tmo_now) state_d = DONE;
         DONE:    if (start) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      running = (state_q == RUN);
      done    = (state_q == DONE);
   end

   always_comb begin
      cycle_d = cycle_q;
      pass_d  = pass_q;
      fail_d  = fail_q;
      halt_d  = halt_q;
      tmo_d   = tmo_q;
      idx_d   = idx_q;
      if (start) begin
         cycle_d = '0;
         pass_d  = 1'b0;
         fail_d  = 1'b0;
         halt_d  = 1'b0;
         tmo_d   = 1'b0;
         idx_d   = '0;
      end else if (state_q == RUN) begin
         cycle_d = cyc_inc;
         if (match) begin
            idx_d  = match_idx;
            pass_d = (match_kind == K_PASS);
            fail_d = (match_kind == K_FAIL);
            halt_d = (match_kind == K_HALT);
         end else if (tmo_now) begin
            tmo_d = 1'b1;
            idx_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_q <= '0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
         halt_q  <= 1'b0;
         tmo_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         cycle_q <= cycle_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         halt_q  <= halt_d;
         tmo_q   <= tmo_d;
         idx_q   <= idx_d;
      end
   end

   assign pass        = pass_q;
   assign fail_hit    = fail_q;
   assign halt_hit    = halt_q;
   assign timeout     = tmo_q;
   assign hit_index   = idx_q;
   assign cycle_count = cycle_q;

`ifdef RVM_MONITOR_STALL_COUNT_EN
   logic [CYC_W-1:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (start) begin
         stall_d = '0;
      end else if ((state_q == RUN) && mem_c_en && mem_stall && !(&stall_q)) begin
         stall_d = stall_q + CYC_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_count = stall_q;
`else
   assign stall_count = '0;
`endif

endmodule

// File: tb/tb_rvm_sim_monitor.sv
// Bench for rvm_sim_monitor: directed scenarios plus randomized runs scored against
// an outcome model that scans each run's stimulus for the first terminating event.
module tb_rvm_sim_monitor;

   localparam logic [31:0] MASK = 32'h0FFF_FFFF;
   localparam int          LIMIT = 60;
`ifdef RVM_MONITOR_STALL_COUNT_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   // Flag vector order: running, done, pass, fail_hit, halt_hit, timeout.
   localparam logic [5:0] F_ZERO = 6'b000000;
   localparam logic [5:0] F_RUN  = 6'b100000;
   localparam logic [5:0] F_PASS = 6'b011000;
   localparam logic [5:0] F_FAIL = 6'b010100;
   localparam logic [5:0] F_HALT = 6'b010010;
   localparam logic [5:0] F_TMO  = 6'b010001;

   logic         clk = 1'b0;
   logic         reset;
   logic [31:0]  mem_addr;
   logic         mem_c_en;
   logic         mem_stall;
   logic [127:0] cfg_addr;
   logic [7:0]   cfg_kind;
   logic [31:0]  cfg_max_cycles;
   logic         start;
   logic         running, done, pass, fail_hit, halt_hit, timeout;
   logic [3:0]   hit_index;
   logic [31:0]  cycle_count, stall_count;

   int checks = 0;
   int errors = 0;

   rvm_sim_monitor dut (
      .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_c_en(mem_c_en),
      .mem_stall(mem_stall), .cfg_addr(cfg_addr), .cfg_kind(cfg_kind),
      .cfg_max_cycles(cfg_max_cycles), .start(start), .running(running),
      .done(done), .pass(pass), .fail_hit(fail_hit), .halt_hit(halt_hit),
      .timeout(timeout), .hit_index(hit_index), .cycle_count(cycle_count),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [5:0] f, input logic [3:0] idx,
                          input logic [31:0] cyc, input logic [31:0] st);
      chk({tag, " flags"}, 64'({running, done, pass, fail_hit, halt_hit, timeout}), 64'(f));
      chk({tag, " hit_index"}, 64'(hit_index), 64'(idx));
      chk({tag, " cycle_count"}, 64'(cycle_count), 64'(cyc));
      chk({tag, " stall_count"}, 64'(stall_count), 64'(st & {32{STALL_EN}}));
   endtask

   task automatic cyc(input logic [31:0] a, input logic e, input logic s);
      mem_addr  = a;
      mem_c_en  = e;
      mem_stall = s;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(32'h0, 1'b0, 1'b0);
   endtask

   task automatic do_start(input logic [31:0] a, input logic e);
      start = 1'b1;
      cyc(a, e, 1'b0);
      start = 1'b0;
   endtask

   task automatic set_ch(input int k, input logic [31:0] a, input logic [1:0] kind);
      cfg_addr[k*32 +: 32] = a;
      cfg_kind[2*k +: 2]   = kind;
   endtask

   // Randomized run: outcome derived by scanning the stimulus for the first terminating event.
   task automatic random_trial(input int t);
      logic [31:0] w [4];
      logic [1:0]  kd [4];
      logic [31:0] a [LIMIT];
      logic        e [LIMIT];
      logic        s [LIMIT];
      logic [31:0] mx;
      int          end_i, hit, st;
      logic [5:0]  ef;
      logic [3:0]  eidx;
      for (int k = 0; k < 4; k++) begin
         w[k]  = $urandom;
         kd[k] = 2'($urandom_range(0, 3));
         set_ch(k, w[k], kd[k]);
      end
      mx = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 70));
      cfg_max_cycles = mx;
      for (int i = 0; i < LIMIT; i++) begin
         e[i] = ($urandom_range(0, 3) != 0);
         s[i] = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 7) == 0) begin
            a[i] = w[$urandom_range(0, 3)];
            a[i][31:28] = 4'($urandom);
         end else begin
            a[i] = $urandom;
         end
      end
      end_i = 0; st = 0; ef = F_RUN; eidx = 4'd0;
      for (int i = 1; i <= LIMIT; i++) begin
         hit = -1;
         if (e[i-1] && !s[i-1]) begin
            for (int k = 3; k >= 0; k--)
               if (kd[k] != 2'b00 && ((a[i-1] & MASK) == (w[k] & MASK))) hit = k;
         end
         if (e[i-1] && s[i-1]) st++;
         if (hit >= 0) begin
            end_i = i;
            eidx  = 4'(hit);
            ef    = (kd[hit] == 2'b01) ? F_PASS : (kd[hit] == 2'b10) ? F_FAIL : F_HALT;
            break;
         end
         if (mx != 0 && i == int'(mx)) begin
            end_i = i;
            ef    = F_TMO;
            break;
         end
      end
      do_start(32'h0, 1'b0);
      for (int i = 1; i <= LIMIT; i++) begin
         cyc(a[i-1], e[i-1], s[i-1]);
         if (end_i == 0 || i < end_i) begin
            chk($sformatf("rnd%0d running c%0d", t, i), 64'(running), 64'd1);
            chk($sformatf("rnd%0d cycle c%0d", t, i), 64'(cycle_count), 64'(i));
         end
      end
      chk_out($sformatf("rnd%0d final", t), ef, eidx, (end_i == 0) ? 32'(LIMIT) : 32'(end_i), 32'(st));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; mem_addr = '0; mem_c_en = 1'b0; mem_stall = 1'b0;
      cfg_addr = '0; cfg_kind = '0; cfg_max_cycles = '0;
      @(posedge clk); #1;
      chk_out("reset", F_ZERO, 4'd0, 32'd0, 32'd0);
      reset = 1'b0;
      idle(3);
      chk_out("idle after reset", F_ZERO, 4'd0, 32'd0, 32'd0);

      set_ch(1, 32'h1000_0200, 2'b01);
      do_start(32'h0, 1'b0);
      chk_out("start", F_RUN, 4'd0, 32'd0, 32'd0);
      idle(9);
      chk_out("pass pre", F_RUN, 4'd0, 32'd9, 32'd0);
      cyc(32'h0000_0200, 1'b1, 1'b0);
      chk_out("pass hit", F_PASS, 4'd1, 32'd10, 32'd0);
      cyc(32'h0000_0200, 1'b1, 1'b1);
      idle(3);
      chk_out("done frozen", F_PASS, 4'd1, 32'd10, 32'd0);

      cfg_kind = '0;
      set_ch(0, 32'h80, 2'b10);
      set_ch(2, 32'h80, 2'b11);
      do_start(32'h0, 1'b0);
      idle(2);
      cyc(32'h80, 1'b1, 1'b0);
      chk_out("priority", F_FAIL, 4'd0, 32'd3, 32'd0);
      cfg_kind[1:0] = 2'b00;
      do_start(32'h80, 1'b1);
      chk_out("no compare on start", F_RUN, 4'd0, 32'd0, 32'd0);
      cyc(32'h80, 1'b1, 1'b0);
      chk_out("halt", F_HALT, 4'd2, 32'd1, 32'd0);

      cfg_kind = '0;
      set_ch(0, 32'h300, 2'b01);
      do_start(32'h0, 1'b0);
      for (int i = 1; i <= 3; i++) cyc(32'h300, 1'b1, 1'b1);
      chk_out("stalled", F_RUN, 4'd0, 32'd3, 32'd3);
      cyc(32'h300, 1'b1, 1'b0);
      chk_out("unstalled", F_PASS, 4'd0, 32'd4, 32'd3);

      cfg_kind = '0;
      cfg_max_cycles = 32'd500;
      do_start(32'h0, 1'b0);
      idle(499);
      chk_out("timeout pre", F_RUN, 4'd0, 32'd499, 32'd0);
      idle(1);
      chk_out("timeout", F_TMO, 4'd0, 32'd500, 32'd0);
      cfg_max_cycles = 32'd0;
      do_start(32'h0, 1'b0);
      idle(1000);
      chk_out("no timeout", F_RUN, 4'd0, 32'd1000, 32'd0);

      cfg_max_cycles = 32'd20;
      set_ch(2, 32'h40, 2'b01);
      do_start(32'h0, 1'b0);
      idle(19);
      cyc(32'h40, 1'b1, 1'b0);
      chk_out("simultaneous", F_PASS, 4'd2, 32'd20, 32'd0);

      do_start(32'h0, 1'b0);
      chk_out("restart from done", F_RUN, 4'd0, 32'd0, 32'd0);
      idle(5);
      do_start(32'h0, 1'b0);
      chk_out("restart in run", F_RUN, 4'd0, 32'd0, 32'd0);

      cfg_max_cycles = 32'd0;
      idle(7);
      #2 reset = 1'b1;
      #1;
      chk_out("async reset", F_ZERO, 4'd0, 32'd0, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      idle(3);
      chk_out("idle after mid reset", F_ZERO, 4'd0, 32'd0, 32'd0);
      do_start(32'h0, 1'b0);
      idle(2);
      cyc(32'hF000_0040, 1'b1, 1'b0);
      chk_out("clean run", F_PASS, 4'd2, 32'd3, 32'd0);

      for (int t = 0; t < 30; t++) random_trial(t);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rvm_sim_monitor.md
# rvm_sim_monitor

Parametrised run-control monitor for the rvm core memory bus. Watches accepted bus transfers against up to NUM_WATCH programmable addresses, each tagged as pass/fail/halt. Also counts run cycles against a configurable timeout and latches a sticky verdict. Sits beside `rvm_core` on the memory bus, in simulation benches and in FPGA self-test builds, and replaces ad-hoc address checks with a reusable, synthesisable block.

## Interface
- NUM_WATCH, 4, number of watch-address channels (1..16)
- ADDR_W, 32, bus address width
- CYC_W, 32, cycle counter width
- IDX_W, 4, width of hit_index (must satisfy 2^IDX_W >= NUM_WATCH)
- ADDR_MASK, 32'h0FFF_FFFF, mask applied to mem_addr and cfg_addr before compare (low ADDR_W bits used)

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- mem_addr  in  ADDR_W  core memory address
- mem_c_en  in  1  core memory request valid
- mem_stall  in  1  memory stall; transfer accepted when mem_c_en && !mem_stall
- cfg_addr  in  NUM_WATCH*ADDR_W  watch addresses, channel k at [k*ADDR_W +: ADDR_W]
- cfg_kind  in  2*NUM_WATCH  channel kind: 00 disabled, 01 pass, 10 fail, 11 halt
- cfg_max_cycles  in  CYC_W  timeout limit; 0 disables timeout
- start  in  1  single-cycle pulse: clear counters/verdict, enter RUN
- running  out  1  high in RUN
- done  out  1  sticky, verdict valid
- pass  out  1  sticky, pass channel hit
- fail_hit  out  1  sticky, fail channel hit
- halt_hit  out  1  sticky, halt channel hit
- timeout  out  1  sticky, cycle limit reached
- hit_index  out  IDX_W  channel that ended the run (0 on timeout)
- cycle_count  out  CYC_W  cycles spent in RUN
- stall_count  out  CYC_W  stalled cycles in RUN (see Configuration)

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE; all outputs 0.
- IDLE: counters hold. start -> RUN, counters and verdict cleared.
- RUN: cycle_count += 1 per cycle, saturating at all-ones. Each cycle with an accepted transfer, compare (mem_addr & ADDR_MASK) with (cfg_addr[k] & ADDR_MASK) for every channel with kind != 00.
- Any match -> DONE. Lowest-index matching channel wins. Its kind sets exactly one of pass/fail_hit/halt_hit. hit_index = k.
- Timeout: in RUN with cfg_max_cycles != 0 and no match this cycle, when the incremented cycle_count equals cfg_max_cycles -> DONE, timeout=1, hit_index=0.
- Match and timeout in the same cycle: match wins, timeout stays 0.
- Non-accepted cycles (mem_c_en=0 or mem_stall=1) never match, even if the address equals a watch address.
- DONE: all outputs frozen; done=1, running=0. start -> RUN (restart with cleared state). Match/timeout ignored.
- start while in RUN: restart; counters cleared that cycle; no compare on that cycle.
- cfg_* sampled every cycle; changes mid-run take effect immediately. The verdict already latched does not change.
- reset at any time: immediate return to IDLE, outputs 0.

## Timing
- Registered outputs. Verdict visible on the cycle after the edge that samples the accepted matching transfer.
- start sampled at edge N: running=1 and cycle_count=0 after edge N. cycle_count=1 after edge N+1.
- Timeout with cfg_max_cycles=M: done=1 and cycle_count=M after edge N+M.
- No combinational path from inputs to outputs.

## Configuration
- RVM_MONITOR_STALL_COUNT_EN defined: stall_count increments (saturating) each RUN cycle with mem_c_en && mem_stall. It clears on start and freezes in DONE/IDLE.
- Undefined: stall_count tied to 0 and the counter is not built. All other behaviour is identical.

## Test plan
- Pass hit: cfg_kind ch1=01, cfg_addr ch1=0x1000_0200, mem_addr=0x0000_0200 accepted at cycle 10 -> next cycle done=1, pass=1, hit_index=1, cycle_count=10.
- Priority: ch0 fail and ch2 halt both at 0x80, accepted access to 0x80 -> fail_hit=1, halt_hit=0, hit_index=0.
- Stalled match ignored: matching address with mem_stall=1 for 3 cycles, then released -> done rises only after the unstalled cycle. With the macro, stall_count=3.
- Timeout: cfg_max_cycles=500, no matches -> done=1, timeout=1, cycle_count=500. Same run with cfg_max_cycles=0 -> still running after 1000 cycles.
- Simultaneous: pass match on the cycle cycle_count reaches cfg_max_cycles=20 -> pass=1, timeout=0.
- Reset mid-run: assert reset at cycle 7 -> all outputs 0 asynchronously. Stays IDLE until start; start then gives a clean run.
